rs_issue_scheduler: RTL
=======================

Name: rs_issue_scheduler

Overview:
- Selects which ready ALU reservation-station entries issue to which free ALU functional units each cycle.
- Sits between the RS entry array and the FU interface.
  - Consumes per-entry "operands ready" flags and per-FU ready.
  - Produces registered per-FU issue pulses with the chosen entry index, plus per-entry pop pulses back to the RS.
- Fairness comes from a rotating round-robin pointer; up to FU_NUM issues per cycle.

Parameters:
- RS_ENTRIES_NUM, `RS_ALU_ENTRIES_NUM: number of RS entries scanned.
- FU_NUM, `NUM_OF_ALUS: number of functional units served.
- ENTRY_IDX_WIDTH, (RS_ENTRIES_NUM<=1)?1:$clog2(RS_ENTRIES_NUM): entry index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- entry_ready  in  RS_ENTRIES_NUM  bit i=1: entry i holds a valid instruction with both operands available.
- fu_ready  in  FU_NUM  bit k=1: FU k can accept an instruction.
- flush  in  1  synchronous; cancels this cycle's selection and clears the in-flight mask.
- fu_valid  out  FU_NUM  registered one-cycle issue pulse per FU.
- fu_entry_idx  out  FU_NUM*ENTRY_IDX_WIDTH  slice k = entry issued to FU k; meaningful only when fu_valid[k]=1.
- rs_pop  out  RS_ENTRIES_NUM  registered one-cycle pulse; bit i set = entry i issued, RS frees it.
- issue_cnt  out  $clog2(FU_NUM+1)  popcount of fu_valid.

Behaviour:
- Reset (reset=0, async):
  - fu_valid=0, fu_entry_idx=0, rs_pop=0, issue_cnt=0.
  - rr_ptr=0, inflight mask=0, fu_hold=0.
- Eligibility in cycle N:
  - elig_e = entry_ready & ~inflight.
  - elig_f = fu_ready & ~fu_hold. fu_hold[k] is the registered fu_valid[k]; it blocks an FU for the one cycle after issue, while its ready deasserts.
- Selection (combinational):
  - Scan entries circularly from rr_ptr: rr_ptr, rr_ptr+1, ... wrapping modulo RS_ENTRIES_NUM.
  - Scan eligible FUs in ascending index.
  - The j-th eligible FU gets the j-th eligible entry.
  - Grants = min(popcount(elig_e), popcount(elig_f)).
- Latency: selection in cycle N is registered at the edge ending N. fu_valid, fu_entry_idx, rs_pop and issue_cnt are visible throughout cycle N+1 for exactly one cycle, then return to 0 unless new grants occur.
- In-flight mask:
  - An entry granted in N is set in inflight at the edge ending N.
  - It is cleared when entry_ready for that entry is sampled 0. This covers the RS deallocating the entry after the pop.
  - No entry is ever granted twice.
- Pointer:
  - After any grant, rr_ptr = (highest-order granted entry in scan order + 1) mod RS_ENTRIES_NUM.
  - With no grants, rr_ptr holds.
- Boundaries:
  - No eligible entry or no eligible FU: all outputs 0 next cycle.
  - All entries ready with FU_NUM >= RS_ENTRIES_NUM: every entry is issued in one cycle.
  - Wrap: with rr_ptr = RS_ENTRIES_NUM-1 the scan continues at entry 0.
- flush=1 in cycle N:
  - No grants registered; fu_valid/rs_pop are 0 in N+1.
  - inflight cleared; rr_ptr reset to 0.
  - fu_hold still follows the registered fu_valid.
- Reset asserted mid-operation: all state cleared immediately (async); pending pulses are dropped.
- RS_ENTRIES_NUM=1 or FU_NUM=1 must be legal.

Optional Feature:
- Macro: RS_ISSUE_PERF_CNT_EN.
- Defined: adds two 32-bit output ports.
  - perf_issue_total: accumulates issue_cnt each cycle.
  - perf_stall_cycles: increments when elig_e != 0 and elig_f == 0.
  - Both saturate at all-ones, reset to 0 asynchronously, and are not cleared by flush.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package rs_sched_pkg:
  - ENTRY_IDX_WIDTH and FU_IDX_WIDTH derivation functions.
  - typedef issue_grant_t {valid, entry_idx}.
  - Function popcount.
- Sub-module rr_multi_picker, purely combinational. Inputs: elig_e, elig_f, rr_ptr. Outputs: grant matrix, per-FU entry index, next_ptr.
- The top level holds the registers: outputs, inflight, fu_hold, rr_ptr, optional counters.

Test Plan:
1. RS_ENTRIES_NUM=8, FU_NUM=2, reset released, entry_ready=8'b0000_0101, fu_ready=2'b11 -> next cycle fu_valid=2'b11, fu_entry_idx[0]=0, fu_entry_idx[1]=2, rs_pop=8'b0000_0101; rr_ptr=3.
2. rr_ptr=7, entry_ready=8'b1000_0011, fu_ready=2'b01 -> FU0 gets entry 7, rs_pop=8'b1000_0000, rr_ptr=0; entries 0/1 issue on following cycles.
3. Entry 4 granted; the RS keeps entry_ready[4]=1 for one extra cycle -> no second grant of entry 4; inflight[4] clears once entry_ready[4]=0.
4. fu_ready=2'b00 with entry_ready=8'hFF for 5 cycles -> fu_valid=0 throughout; with RS_ISSUE_PERF_CNT_EN, perf_stall_cycles=5.
5. flush=1 in the same cycle as entry_ready=8'h01, fu_ready=2'b01 -> fu_valid=0 next cycle, rr_ptr=0; entry 0 issues the cycle after flush drops.
6. reset driven low between edges while fu_valid=2'b10 -> fu_valid, rs_pop and issue_cnt go to 0 immediately without waiting for clk.

Source files
------------

// File: rtl/rs_sched_pkg.sv
// ---------------------------------------------------------------------------
// rs_sched_pkg
// Shared definitions for the ALU reservation-station issue scheduler:
//   - default sizing (matching the core-level RS_ALU_ENTRIES_NUM and
//     NUM_OF_ALUS configuration values)
//   - index-width derivation helpers
//   - issue_grant_t, the {valid, entry_idx} view of one FU issue slot
//   - popcount helper
// ---------------------------------------------------------------------------
package rs_sched_pkg;

    localparam int DEFAULT_RS_ENTRIES = 8;

    localparam int DEFAULT_FU_NUM = 2;

    // Widest entry index any configuration may use (up to 256 entries).
    localparam int MAX_ENTRY_IDX_WIDTH = 8;

    // A single-entry array still needs a 1-bit index so ports never collapse.
    function automatic int entry_idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int fu_idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // One FU issue slot as seen by downstream FU interface logic.
    typedef struct packed {
        logic                           valid;
        logic [MAX_ENTRY_IDX_WIDTH-1:0] entry_idx;
    } issue_grant_t;

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + {31'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rr_multi_picker.sv
// ---------------------------------------------------------------------------
// rr_multi_picker
// Purely combinational multi-grant round-robin selector. Eligible entries are
// visited circularly starting at rr_ptr_i; eligible FUs are visited in
// ascending order; the j-th eligible entry is paired with the j-th eligible FU.
//
// Ports:
//   elig_e_i        [RS_ENTRIES_NUM]  entries that may issue this cycle
//   elig_f_i        [FU_NUM]          FUs that may accept this cycle
//   rr_ptr_i        [IW]              scan start entry
//   grant_o         [FU_NUM][RS_ENTRIES_NUM] one-hot entry per granted FU
//   fu_grant_o      [FU_NUM]          FU k received an entry
//   fu_entry_idx_o  [FU_NUM][IW]      entry given to FU k (0 when none)
//   any_grant_o     1                 at least one grant made
//   next_ptr_o      [IW]              one past the last granted entry (wraps)
// ---------------------------------------------------------------------------
module rr_multi_picker
    import rs_sched_pkg::*;
#(
    parameter  int RS_ENTRIES_NUM = DEFAULT_RS_ENTRIES,
    parameter  int FU_NUM         = DEFAULT_FU_NUM,
    localparam int IW             = entry_idx_width(RS_ENTRIES_NUM)
) (
    input  logic [RS_ENTRIES_NUM-1:0]             elig_e_i,
    input  logic [FU_NUM-1:0]                     elig_f_i,
    input  logic [IW-1:0]                         rr_ptr_i,
    output logic [FU_NUM-1:0][RS_ENTRIES_NUM-1:0] grant_o,
    output logic [FU_NUM-1:0]                     fu_grant_o,
    output logic [FU_NUM-1:0][IW-1:0]             fu_entry_idx_o,
    output logic                                  any_grant_o,
    output logic [IW-1:0]                         next_ptr_o
);

    // fu_cur remembers the first FU not yet examined, so each FU is taken at
    // most once and in ascending order while entries arrive in scan order.
    always_comb begin
        int          e;
        int          fu_cur;
        int          last;
        int          nxt;
        logic        found;
        logic [IW-1:0] eidx;

        grant_o        = '0;
        fu_grant_o     = '0;
        fu_entry_idx_o = '0;
        any_grant_o    = 1'b0;
        next_ptr_o     = rr_ptr_i;
        e              = 0;
        fu_cur         = 0;
        last           = 0;
        nxt            = 0;
        found          = 1'b0;
        eidx           = '0;

        for (int s = 0; s < RS_ENTRIES_NUM; s++) begin
            e = int'(rr_ptr_i) + s;
            if (e >= RS_ENTRIES_NUM) begin
                e = e - RS_ENTRIES_NUM;
            end
            eidx = IW'(e);
            if (elig_e_i[eidx]) begin
                found = 1'b0;
                for (int k = 0; k < FU_NUM; k++) begin
                    if (!found && (k >= fu_cur) && elig_f_i[k]) begin
                        grant_o[k][eidx]  = 1'b1;
                        fu_grant_o[k]     = 1'b1;
                        fu_entry_idx_o[k] = eidx;
                        found             = 1'b1;
                        fu_cur            = k + 1;
                        last              = e;
                        any_grant_o       = 1'b1;
                    end
                end
            end
        end

        if (any_grant_o) begin
            nxt = last + 1;
            if (nxt >= RS_ENTRIES_NUM) begin
                nxt = 0;
            end
            next_ptr_o = IW'(nxt);
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// ---------------------------------------------------------------------------
// rs_issue_scheduler
// Chooses which ready ALU reservation-station entries issue to which free ALU
// functional units each cycle, with a rotating round-robin start pointer for
// fairness. All outputs are registered one-cycle pulses.
//
// Optional feature macro: RS_ISSUE_PERF_CNT_EN adds saturating 32-bit
// perf_issue_total and perf_stall_cycles counters.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous reset, active LOW
//   entry_ready   in   [RS_ENTRIES_NUM] entry i valid with operands ready
//   fu_ready      in   [FU_NUM] FU k can accept an instruction
//   flush         in   synchronous cancel of this cycle's selection
//   fu_valid      out  [FU_NUM] issue pulse per FU
//   fu_entry_idx  out  [FU_NUM*ENTRY_IDX_WIDTH] slice k = entry for FU k
//   rs_pop        out  [RS_ENTRIES_NUM] entry i issued, RS may free it
//   issue_cnt     out  popcount of fu_valid
// ---------------------------------------------------------------------------
module rs_issue_scheduler
    import rs_sched_pkg::*;
#(
    parameter  int RS_ENTRIES_NUM  = DEFAULT_RS_ENTRIES,
    parameter  int FU_NUM          = DEFAULT_FU_NUM,
    localparam int ENTRY_IDX_WIDTH = entry_idx_width(RS_ENTRIES_NUM),
    localparam int CNT_W           = $clog2(FU_NUM + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [RS_ENTRIES_NUM-1:0]         entry_ready,
    input  logic [FU_NUM-1:0]                 fu_ready,
    input  logic                              flush,
    output logic [FU_NUM-1:0]                 fu_valid,
    output logic [FU_NUM*ENTRY_IDX_WIDTH-1:0] fu_entry_idx,
    output logic [RS_ENTRIES_NUM-1:0]         rs_pop,
    output logic [CNT_W-1:0]                  issue_cnt
`ifdef RS_ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]                       perf_issue_total,
    output logic [31:0]                       perf_stall_cycles
`endif
);

    localparam int IW = ENTRY_IDX_WIDTH;

    logic [FU_NUM-1:0]                     fu_valid_q, fu_valid_d;
    logic [FU_NUM-1:0][IW-1:0]             fu_idx_q, fu_idx_d;
    logic [RS_ENTRIES_NUM-1:0]             rs_pop_q, rs_pop_d;
    logic [CNT_W-1:0]                      issue_cnt_q, issue_cnt_d;
    logic [RS_ENTRIES_NUM-1:0]             inflight_q, inflight_d;
    logic [IW-1:0]                         rr_ptr_q, rr_ptr_d;

    logic [FU_NUM-1:0]                     fu_hold;
    logic [RS_ENTRIES_NUM-1:0]             elig_e;
    logic [FU_NUM-1:0]                     elig_f;
    logic [FU_NUM-1:0][RS_ENTRIES_NUM-1:0] pick_grant;
    logic [FU_NUM-1:0]                     pick_fu_grant;
    logic [FU_NUM-1:0][IW-1:0]             pick_idx;
    logic                                  pick_any;
    logic [IW-1:0]                         pick_next_ptr;

    // An FU that issued last edge is still lowering its ready, so the
    // registered issue pulse itself masks it for one cycle.
    assign fu_hold = fu_valid_q;
    assign elig_e  = entry_ready & ~inflight_q;
    assign elig_f  = fu_ready & ~fu_hold;

    rr_multi_picker #(
        .RS_ENTRIES_NUM (RS_ENTRIES_NUM),
        .FU_NUM         (FU_NUM)
    ) u_picker (
        .elig_e_i       (elig_e),
        .elig_f_i       (elig_f),
        .rr_ptr_i       (rr_ptr_q),
        .grant_o        (pick_grant),
        .fu_grant_o     (pick_fu_grant),
        .fu_entry_idx_o (pick_idx),
        .any_grant_o    (pick_any),
        .next_ptr_o     (pick_next_ptr)
    );

    // Next-state: an in-flight entry stays masked until the RS drops its
    // ready, which guarantees no entry is granted twice for one allocation.
    always_comb begin
        fu_valid_d  = '0;
        fu_idx_d    = '0;
        rs_pop_d    = '0;
        issue_cnt_d = '0;
        inflight_d  = '0;
        rr_ptr_d    = rr_ptr_q;

        if (!flush) begin
            fu_valid_d = pick_fu_grant;
            fu_idx_d   = pick_idx;
            for (int k = 0; k < FU_NUM; k++) begin
                rs_pop_d = rs_pop_d | pick_grant[k];
            end
            inflight_d = (inflight_q & entry_ready) | rs_pop_d;
            if (pick_any) begin
                rr_ptr_d = pick_next_ptr;
            end
        end else begin
            rr_ptr_d = '0;
        end

        issue_cnt_d = CNT_W'(popcount(64'(fu_valid_d)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fu_valid_q  <= '0;
            fu_idx_q    <= '0;
            rs_pop_q    <= '0;
            issue_cnt_q <= '0;
            inflight_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            fu_valid_q  <= fu_valid_d;
            fu_idx_q    <= fu_idx_d;
            rs_pop_q    <= rs_pop_d;
            issue_cnt_q <= issue_cnt_d;
            inflight_q  <= inflight_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign fu_valid     = fu_valid_q;
    assign fu_entry_idx = fu_idx_q;
    assign rs_pop       = rs_pop_q;
    assign issue_cnt    = issue_cnt_q;

`ifdef RS_ISSUE_PERF_CNT_EN
    logic [31:0] perf_total_q, perf_total_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [32:0] total_sum;

    // Both counters saturate rather than wrap and deliberately ignore flush.
    always_comb begin
        total_sum    = {1'b0, perf_total_q} + 33'(issue_cnt_q);
        perf_total_d = total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
        perf_stall_d = perf_stall_q;
        if ((|elig_e) && !(|elig_f) && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_total_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_total_q <= perf_total_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_issue_total  = perf_total_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule
